// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 execute-stage types, opcode constants and decode helper
package chip8_pkg;

    typedef enum logic [3:0] {
        SET, OR, AND, XOR, SUM, SUB, SHIFT_RIGHT, NEG_SUB, SHIFT_LEFT
    } operator_t;

    typedef enum logic [1:0] {IDLE, EXEC, WB_X, WB_F} seq_state_t;

    localparam logic [3:0] OPC_LDI  = 4'h6;
    localparam logic [3:0] OPC_ADDI = 4'h7;
    localparam logic [3:0] OPC_ALU  = 4'h8;

    typedef struct packed {
        logic      legal;
        operator_t op;
        logic      use_nn;
        logic      arith;   // 8XY4..8XYE: always writes the flag register
    } dec_t;

    function automatic dec_t decode_op(input logic [15:0] opc);
        dec_t d;
        d = '{legal: 1'b1, op: SET, use_nn: 1'b0, arith: 1'b0};
        case (opc[15:12])
            OPC_LDI:  d.use_nn = 1'b1;
            OPC_ADDI: begin
                d.op     = SUM;
                d.use_nn = 1'b1;
            end
            OPC_ALU: begin
                d.arith = |opc[3:2];
                case (opc[3:0])
                    4'h0:    d.op = SET;
                    4'h1:    d.op = OR;
                    4'h2:    d.op = AND;
                    4'h3:    d.op = XOR;
                    4'h4:    d.op = SUM;
                    4'h5:    d.op = SUB;
                    4'h6:    d.op = SHIFT_RIGHT;
                    4'h7:    d.op = NEG_SUB;
                    4'hE:    d.op = SHIFT_LEFT;
                    default: d.legal = 1'b0;
                endcase
            end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/vreg_file.sv
// rtl/vreg_file.sv - V0..VF register file, one write port, operand and debug read ports
module vreg_file
    import chip8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] op_addr,
    output logic [7:0] op_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] regs_q [16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign op_data = regs_q[op_addr];
    assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage sequencer for CHIP-8 6XNN/7XNN/8XYN opcodes
module alu_exec_seq
    import chip8_pkg::*;
#(
    parameter logic [3:0] FLAG_REG        = 4'hF,
    parameter bit         LOGIC_WRITES_VF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output operator_t   alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        illegal
);

    seq_state_t  state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] opcode_q, opcode_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    operator_t   alu_op_q, alu_op_d;
    logic        wf_q, wf_d;
    logic [7:0]  res_q, res_d;
    logic        cf_q, cf_d;

    logic        we;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic [3:0]  op_raddr;
    logic [7:0]  op_rdata;
    logic [3:0]  x_idx, y_idx;
    dec_t        dec;

    assign x_idx = opcode_q[11:8];
    assign y_idx = opcode_q[7:4];
    assign dec   = decode_op(opcode_q);

    vreg_file u_vregs (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .op_addr (op_raddr),
        .op_data (op_rdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            opcode_q <= 16'h0000;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= SET;
            wf_q     <= 1'b0;
            res_q    <= 8'h00;
            cf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            opcode_q <= opcode_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            wf_q     <= wf_d;
            res_q    <= res_d;
            cf_q     <= cf_d;
        end
    end

    // The cycle after a transfer stays in IDLE with pend_q set: the opcode is decoded,
    // an illegal one is reported, and a legal one fetches operand b before EXEC.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        opcode_d = opcode_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        wf_d     = wf_q;
        res_d    = res_q;
        cf_d     = cf_q;
        op_ready = 1'b0;
        illegal  = 1'b0;
        done     = 1'b0;
        we       = 1'b0;
        waddr    = x_idx;
        wdata    = res_q;
        op_raddr = y_idx;
        unique case (state_q)
            IDLE: begin
                op_ready = ~pend_q;
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (dec.legal) begin
                        alu_b_d  = dec.use_nn ? opcode_q[7:0] : op_rdata;
                        alu_op_d = dec.op;
                        wf_d     = dec.arith |
                                   ((opcode_q[15:12] == OPC_ALU) & LOGIC_WRITES_VF);
                        state_d  = EXEC;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (op_valid) begin
                    opcode_d = opcode;
                    pend_d   = 1'b1;
                end
            end
            EXEC: begin
                op_raddr = x_idx;
                alu_a_d  = op_rdata;
                res_d    = alu_out;
                cf_d     = alu_carry;
                state_d  = WB_X;
            end
            WB_X: begin
                we      = 1'b1;
                done    = ~wf_q;
                state_d = wf_q ? WB_F : IDLE;
            end
            WB_F: begin
                we      = 1'b1;
                waddr   = FLAG_REG;
                wdata   = {7'b0, cf_q};
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Operand a comes straight from the register file during EXEC so X=Y sees one value.
    assign alu_a  = (state_q == EXEC) ? op_rdata : alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - directed self-checking bench for alu_exec_seq with a CHIP-8 ALU beside it
module tb_alu_exec_seq;
    import chip8_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_v, sel;
    logic [15:0] opcode_v;
    logic [3:0]  rd_addr_v;
    logic        op_valid0, op_valid1, ready0, ready1, done0, done1, ill0, ill1, c0, c1;
    logic [7:0]  a0, b0, o0, rd0, a1, b1, o1, rd1;
    operator_t   op0, op1;
    logic        ready_s, done_s, ill_s;
    logic [7:0]  rd_s;
    int          errors, checks;
    logic [7:0]  exp_v [16];

    function automatic logic [8:0] alu_model(operator_t op, logic [7:0] a, logic [7:0] b);
        case (op)
            SET:         return {1'b0, b};
            OR:          return {1'b0, a | b};
            AND:         return {1'b0, a & b};
            XOR:         return {1'b0, a ^ b};
            SUM:         return {1'b0, a} + {1'b0, b};
            SUB:         return {a >= b, a - b};
            NEG_SUB:     return {b >= a, b - a};
            SHIFT_RIGHT: return {b[0], 1'b0, b[7:1]};
            SHIFT_LEFT:  return {b[7], b[6:0], 1'b0};
            default:     return 9'h000;
        endcase
    endfunction

    assign op_valid0 = valid_v & ~sel;
    assign op_valid1 = valid_v & sel;
    assign {c0, o0}  = alu_model(op0, a0, b0);
    assign {c1, o1}  = alu_model(op1, a1, b1);
    assign ready_s   = sel ? ready1 : ready0;
    assign done_s    = sel ? done1  : done0;
    assign ill_s     = sel ? ill1   : ill0;
    assign rd_s      = sel ? rd1    : rd0;

    alu_exec_seq #(.FLAG_REG(4'hF), .LOGIC_WRITES_VF(1'b1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid0), .op_ready(ready0), .opcode(opcode_v),
        .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_out(o0), .alu_carry(c0),
        .rd_addr(rd_addr_v), .rd_data(rd0), .done(done0), .illegal(ill0));

    alu_exec_seq #(.FLAG_REG(4'hF), .LOGIC_WRITES_VF(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(ready1), .opcode(opcode_v),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_out(o1), .alu_carry(c1),
        .rd_addr(rd_addr_v), .rd_data(rd1), .done(done1), .illegal(ill1));

    task automatic read_v(input logic [3:0] a, output logic [7:0] d);
        rd_addr_v = a;
        #1;
        d = rd_s;
    endtask

    // Called at a negedge; returns the edge index (transfer = edge 0) of done/illegal.
    task automatic exec_op(input logic [15:0] op, output int done_edge, output int ill_edge,
                           output logic ready2);
        int n;
        n = 0;
        done_edge = -1;
        ill_edge  = -1;
        ready2    = 1'b0;
        while (!ready_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_s !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout op=%h op_ready=%b required=1", op, ready_s);
        end
        valid_v  = 1'b1;
        opcode_v = op;
        @(posedge clk);
        #1;
        valid_v  = 1'b0;
        opcode_v = 16'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done_s && done_edge < 0) done_edge = k;
            if (ill_s && ill_edge < 0) ill_edge = k;
            if (k == 2) ready2 = ready_s;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int bad;
        bad = 0;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_op_ready got=%b%b exp=11", ready0, ready1);
        end
        checks++;
        if (done0 !== 1'b0 || ill0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses done=%b illegal=%b exp=0/0", done0, ill0);
        end
        checks++;
        if (a0 !== 8'h00 || b0 !== 8'h00 || op0 !== SET) begin
            errors++;
            $display("FAIL reset_alu_ports a=%h b=%h op=%0d exp=00/00/SET", a0, b0, op0);
        end
        for (int i = 0; i < 16; i++) begin
            read_v(4'(i), d);
            if (d !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_regs nonzero=%0d exp=0", bad);
        end
    endtask

    task automatic test_sum();
        int de, ie;
        logic r2;
        logic [7:0] d;
        exec_op(16'h63F0, de, ie, r2);
        checks++;
        if (de != 3) begin errors++; $display("FAIL ldi_done_edge got=%0d exp=3", de); end
        exec_op(16'h6420, de, ie, r2);
        exec_op(16'h8344, de, ie, r2);
        exp_v[3] = 8'h10; exp_v[4] = 8'h20; exp_v[15] = 8'h01;
        checks++;
        if (de != 4) begin errors++; $display("FAIL sum_done_edge got=%0d exp=4", de); end
        read_v(4'h3, d);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL sum_v3 got=%h exp=10", d); end
        read_v(4'hF, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL sum_vf got=%h exp=01", d); end
    endtask

    task automatic test_sub();
        int de, ie;
        logic r2;
        logic [7:0] d;
        exec_op(16'h6505, de, ie, r2);
        exec_op(16'h6607, de, ie, r2);
        exec_op(16'h8565, de, ie, r2);
        read_v(4'h5, d);
        checks++;
        if (d !== 8'hFE) begin errors++; $display("FAIL sub_v5 got=%h exp=fe", d); end
        read_v(4'hF, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL sub_vf got=%h exp=00", d); end
        exec_op(16'h6505, de, ie, r2);
        exec_op(16'h8567, de, ie, r2);
        exp_v[5] = 8'h02; exp_v[6] = 8'h07; exp_v[15] = 8'h01;
        read_v(4'h5, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL negsub_v5 got=%h exp=02", d); end
        read_v(4'hF, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL negsub_vf got=%h exp=01", d); end
    endtask

    task automatic test_shift();
        int de, ie;
        logic r2;
        logic [7:0] d, f;
        exec_op(16'h6281, de, ie, r2);
        exec_op(16'h8E26, de, ie, r2);
        read_v(4'hE, d);
        read_v(4'hF, f);
        checks++;
        if (d !== 8'h40 || f !== 8'h01) begin
            errors++;
            $display("FAIL shr_ve_vf got=%h/%h exp=40/01", d, f);
        end
        exec_op(16'h8E2E, de, ie, r2);
        exp_v[2] = 8'h81; exp_v[14] = 8'h02; exp_v[15] = 8'h01;
        read_v(4'hE, d);
        read_v(4'hF, f);
        checks++;
        if (d !== 8'h02 || f !== 8'h01) begin
            errors++;
            $display("FAIL shl_ve_vf got=%h/%h exp=02/01", d, f);
        end
    endtask

    task automatic test_flag_dest();
        int de, ie;
        logic r2;
        logic [7:0] d;
        exec_op(16'h6F10, de, ie, r2);
        exec_op(16'h60F5, de, ie, r2);
        exec_op(16'h8F04, de, ie, r2);
        exp_v[0] = 8'hF5; exp_v[15] = 8'h01;
        read_v(4'hF, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL flag_dest_vf got=%h exp=01", d); end
    endtask

    task automatic test_addi();
        int de, ie;
        logic r2;
        logic [7:0] d, f;
        exec_op(16'h6F55, de, ie, r2);
        exec_op(16'h6A02, de, ie, r2);
        exec_op(16'h7AFF, de, ie, r2);
        exp_v[10] = 8'h01; exp_v[15] = 8'h55;
        read_v(4'hA, d);
        read_v(4'hF, f);
        checks++;
        if (d !== 8'h01 || f !== 8'h55) begin
            errors++;
            $display("FAIL addi_va_vf got=%h/%h exp=01/55", d, f);
        end
        checks++;
        if (de != 3) begin errors++; $display("FAIL addi_done_edge got=%0d exp=3", de); end
    endtask

    task automatic test_illegal();
        int de, ie, bad;
        logic r2;
        logic [7:0] d;
        exec_op(16'h812F, de, ie, r2);
        checks++;
        if (ie != 1 || de != -1 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL illegal_alu ill_edge=%0d done_edge=%0d ready=%b exp=1/-1/1", ie, de, r2);
        end
        exec_op(16'h1234, de, ie, r2);
        checks++;
        if (ie != 1 || de != -1) begin
            errors++;
            $display("FAIL illegal_top ill_edge=%0d done_edge=%0d exp=1/-1", ie, de);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_v(4'(i), d);
            if (d !== exp_v[i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL illegal_regs changed=%0d exp=0", bad); end
    endtask

    task automatic test_logic();
        int de, ie;
        logic r2;
        logic [7:0] d, f;
        exec_op(16'h8121, de, ie, r2);
        read_v(4'h1, d);
        read_v(4'hF, f);
        checks++;
        if (d !== 8'h81 || f !== 8'h00 || de != 4) begin
            errors++;
            $display("FAIL logic_vf v1=%h vf=%h done_edge=%0d exp=81/00/4", d, f, de);
        end
    endtask

    task automatic test_logic_novf();
        int de, ie;
        logic r2;
        logic [7:0] d, f;
        sel = 1'b1;
        exec_op(16'h6F01, de, ie, r2);
        exec_op(16'h6133, de, ie, r2);
        exec_op(16'h6255, de, ie, r2);
        exec_op(16'h8123, de, ie, r2);
        read_v(4'h1, d);
        read_v(4'hF, f);
        checks++;
        if (d !== 8'h66 || f !== 8'h01 || de != 3) begin
            errors++;
            $display("FAIL logic_novf v1=%h vf=%h done_edge=%0d exp=66/01/3", d, f, de);
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [4];
        int t [4];
        int i, cyc;
        logic [7:0] d0, d1, d3, df;
        seq = '{16'h6011, 16'h6122, 16'h8014, 16'h6344};
        i = 0;
        cyc = 0;
        valid_v = 1'b1;
        opcode_v = seq[0];
        while (i < 4 && cyc < 80) begin
            if (ready_s) begin
                t[i] = cyc;
                i++;
            end
            @(posedge clk);
            #1;
            if (i < 4) opcode_v = seq[i];
            else valid_v = 1'b0;
            cyc++;
            @(negedge clk);
        end
        valid_v = 1'b0;
        checks++;
        if (i != 4) begin
            errors++;
            $display("FAIL b2b_transfers got=%0d exp=4", i);
        end else begin
            checks++;
            if (t[1] - t[0] != 4 || t[2] - t[1] != 4 || t[3] - t[2] != 5) begin
                errors++;
                $display("FAIL b2b_gaps got=%0d/%0d/%0d exp=4/4/5", t[1] - t[0], t[2] - t[1],
                         t[3] - t[2]);
            end
        end
        repeat (8) @(negedge clk);
        read_v(4'h0, d0);
        read_v(4'h1, d1);
        read_v(4'h3, d3);
        read_v(4'hF, df);
        checks++;
        if (d0 !== 8'h33 || d1 !== 8'h22 || d3 !== 8'h44 || df !== 8'h00) begin
            errors++;
            $display("FAIL b2b_regs got=%h/%h/%h/%h exp=33/22/44/00", d0, d1, d3, df);
        end
    endtask

    task automatic test_reset_mid();
        int de, ie, bad, seen;
        logic r2;
        logic [7:0] d;
        exec_op(16'h6380, de, ie, r2);
        exec_op(16'h6490, de, ie, r2);
        valid_v  = 1'b1;
        opcode_v = 16'h8344;
        @(posedge clk);
        #1;
        valid_v = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (done0) seen++;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_done pulses=%0d exp=0", seen); end
        checks++;
        if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready0); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_v(4'(i), d);
            if (d !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_mid_regs nonzero=%0d exp=0", bad); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        valid_v   = 1'b0;
        sel       = 1'b0;
        opcode_v  = 16'h0000;
        rd_addr_v = 4'h0;
        for (int i = 0; i < 16; i++) exp_v[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_sum();
        test_sub();
        test_shift();
        test_flag_dest();
        test_addi();
        test_illegal();
        test_logic();
        test_logic_novf();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
